mat2_vec_seq: RTL and testbench
===============================

Name: mat2_vec_seq

Overview:
- Sequencer that computes y = A·b for a 2x2 matrix A and 2-vector b, all Q8.8 two's-complement.
- Sits directly upstream of the combinational 2-element dot-product unit Mul2vector, which computes C = A0·B0 + A1·B1.
- Receives A and b as a serial word stream and presents row 0, then row 1, with b to Mul2vector.
- Captures each C and emits the pair {y0, y1} on a valid/ready result port.

Parameters:
- W, 16, data word width (Q8.8, two's complement).
- DP_LAT, 1, cycles from operand presentation to C sampling. Must be ≥1. Covers the combinational unit plus any later-registered variant.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low. Asserts immediately; release is synchronous to clk in the system.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  W  input word. Order: A00, A01, A10, A11, B0, B1.
- dp_a0  out  W  operand A0 to Mul2vector.
- dp_a1  out  W  operand A1 to Mul2vector.
- dp_b0  out  W  operand B0 to Mul2vector.
- dp_b1  out  W  operand B1 to Mul2vector.
- dp_c  in  W  result C from Mul2vector.
- out_valid  out  1  result pair valid.
- out_ready  in  1  downstream accepts the pair.
- out_y0  out  W  row-0 result.
- out_y1  out  W  row-1 result.
- busy  out  1  high in any state other than LOAD with load count 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=LOAD, load count=0, wait counter=0.
  - All six operand registers = 0, y0=y1=0.
  - out_valid=0, busy=0. in_ready=1 after release.
  - dp_* outputs = 0.
- A reset asserted mid-operation aborts the operation. Partial loads and pending results are discarded. No output handshake completes.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready stores in_data into register[load count] and increments the count (0..5).
  - On the handshake at count 5, go to ROW0 and reset the count to 0.
  - in_valid low stalls without penalty. There is no timeout.
- ROW0:
  - in_ready=0.
  - dp_a0=A00, dp_a1=A01, dp_b0=B0, dp_b1=B1, stable for the whole state.
  - The wait counter counts DP_LAT cycles. In the last of those cycles, register y0 <= dp_c and go to ROW1.
  - With DP_LAT=1, ROW0 lasts exactly 1 cycle.
- ROW1:
  - Same as ROW0 with dp_a0=A10, dp_a1=A11. B is unchanged.
  - Captures y1, then goes to DONE.
- DONE:
  - out_valid=1, out_y0/out_y1 held stable. in_ready=0.
  - out_valid&&out_ready returns to LOAD (count 0). out_valid deasserts the next cycle.
  - out_ready low holds DONE indefinitely. Outputs must not change while waiting.
- dp_* in LOAD and DONE: drive the row-1 operands (last presented). Do not switch to X or 0. This avoids needless toggling.
- Latency with DP_LAT=1 and no stalls: last input handshake at cycle t, out_valid high at t+3 (ROW0 at t+1, ROW1 at t+2, DONE at t+3).
- Throughput: one matrix-vector product per 6 + 2·DP_LAT + 1 cycles minimum. Load of the next job does not overlap DONE.
- Arithmetic:
  - No arithmetic in this block. dp_c is captured bit-exact.
  - Overflow, rounding and truncation of the product are owned by Mul2vector.
- A and b are reloaded for every job. Previous register contents are never reused.
- Illegal state encodings recover to LOAD on the next clock.

Decomposition:
- Shared package mat_pkg holds:
  - W=16 and FRAC=8.
  - State encoding: LOAD, ROW0, ROW1, DONE.
  - Load index constants: IDX_A00 through IDX_B1, values 0..5.
- Mul2vector is instantiated at the level above, not inside this block. This keeps the block verifiable against a behavioural dot-product model.
- No sub-module needed. The FSM, load counter, wait counter and operand mux fit in one module.

Test Plan:
1. Reset then a single job:
   - Stream FE80, FE80, FE80, FE80, 0080, FC80 with Mul2vector attached.
   - Expect y0 = y1 = 0480 (-1.5·0.5 + -1.5·-3.5 = 4.5).
   - out_valid rises 3 cycles after the last in handshake.
2. Operand sequencing with a model dp_c:
   - A = 0100, 0000, 0000, 0200; b = 0300, 0400. Check dp_* each cycle.
   - Expect ROW0 to present {0100, 0000, 0300, 0400} and ROW1 to present {0000, 0200, 0300, 0400}.
   - Expect y0 = 0300, y1 = 0800.
3. Input gaps plus output backpressure:
   - Insert random in_valid gaps and hold out_ready=0 for 10 cycles.
   - Expect in_ready=0, out_valid=1 and stable outputs throughout the stall.
   - Expect a single handshake on release.
4. Back-to-back jobs:
   - Second job A = 0080 ×4, b = 0100, 0100.
   - Expect the result 0100, 0100.
   - No data from job 1 leaks into job 2.
5. Reset mid-operation:
   - Assert rst_n after 3 loaded words, and again during DONE.
   - Expect out_valid=0 immediately (asynchronously), state LOAD, and a clean next job.
6. DP_LAT=3 build:
   - dp_c model changes 2 cycles after the operands change.
   - Expect the correct capture and out_valid 7 cycles after the last input handshake.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared constants and state encoding for the 2x2 matrix-vector sequencer.
package mat_pkg;
    localparam int W      = 16;
    localparam int FRAC   = 8;
    localparam int NWORDS = 6;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ROW0 = 2'd1,
        ROW1 = 2'd2,
        DONE = 2'd3
    } state_e;

    // Position of each operand in the serial input stream
    localparam logic [2:0] IDX_A00 = 3'd0;
    localparam logic [2:0] IDX_A01 = 3'd1;
    localparam logic [2:0] IDX_A10 = 3'd2;
    localparam logic [2:0] IDX_A11 = 3'd3;
    localparam logic [2:0] IDX_B0  = 3'd4;
    localparam logic [2:0] IDX_B1  = 3'd5;
endpackage

// File: rtl/mat2_vec_seq.sv
// Loads A (2x2) and b serially, presents each row with b to an external
// dot-product unit, captures both results and offers them on a valid/ready port.
module mat2_vec_seq #(
    parameter int W      = mat_pkg::W,
    parameter int DP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] dp_a0,
    output logic [W-1:0] dp_a1,
    output logic [W-1:0] dp_b0,
    output logic [W-1:0] dp_b1,
    input  logic [W-1:0] dp_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y0,
    output logic [W-1:0] out_y1,
    output logic         busy
);
    import mat_pkg::*;

    localparam int WAIT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    state_e                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic [NWORDS-1:0][W-1:0]  opnd_q, opnd_d;
    logic [W-1:0]              y0_q, y0_d, y1_q, y1_d;
    logic                      wait_last;

    assign wait_last = (wait_q == WAIT_W'(DP_LAT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        opnd_d  = opnd_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q <= IDX_B1) opnd_d[cnt_q] = in_data;
                    // An out-of-range count is treated as the final word
                    if (cnt_q >= IDX_B1) begin
                        cnt_d   = 3'd0;
                        state_d = ROW0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ROW0: begin
                if (wait_last) begin
                    y0_d    = dp_c;
                    wait_d  = '0;
                    state_d = ROW1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ROW1: begin
                if (wait_last) begin
                    y1_d    = dp_c;
                    wait_d  = '0;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = LOAD;
                    cnt_d   = 3'd0;
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = 3'd0;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= 3'd0;
            wait_q  <= '0;
            opnd_q  <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            opnd_q  <= opnd_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DONE);
    assign busy      = !((state_q == LOAD) && (cnt_q == 3'd0));

    // Outside ROW0 the row-1 operands stay on the bus to avoid toggling
    assign dp_a0  = (state_q == ROW0) ? opnd_q[IDX_A00] : opnd_q[IDX_A10];
    assign dp_a1  = (state_q == ROW0) ? opnd_q[IDX_A01] : opnd_q[IDX_A11];
    assign dp_b0  = opnd_q[IDX_B0];
    assign dp_b1  = opnd_q[IDX_B1];
    assign out_y0 = y0_q;
    assign out_y1 = y1_q;
endmodule

// File: tb/tb_mat2_vec_seq.sv
// Drives a DP_LAT=1 and a DP_LAT=3 sequencer against a behavioural Q8.8 dot-product model.
module tb_mat2_vec_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       in_valid, out_ready;
    logic [1:0][15:0] in_data;
    wire  [1:0]       in_ready, out_valid, busy;
    wire  [1:0][15:0] dp_a0, dp_a1, dp_b0, dp_b1, out_y0, out_y1;
    logic [15:0]      dpc_comb, dpc_p1, dpc_p2;

    int n_chk = 0;
    int n_fail = 0;

    // Q8.8 x Q8.8 summed, truncated back to Q8.8
    function automatic logic [15:0] dot(input logic [15:0] a0, a1, b0, b1);
        longint p;
        p = longint'($signed(a0)) * longint'($signed(b0))
          + longint'($signed(a1)) * longint'($signed(b1));
        return p[23:8];
    endfunction

    function automatic int lat(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic logic [5:0][15:0] mk(input logic [15:0] a00, a01, a10, a11, b0, b1);
        return {b1, b0, a11, a10, a01, a00};
    endfunction

    assign dpc_comb = dot(dp_a0[0], dp_a1[0], dp_b0[0], dp_b1[0]);
    // Slow variant: result appears two cycles after the operands change
    always @(posedge clk) begin
        dpc_p1 <= dot(dp_a0[1], dp_a1[1], dp_b0[1], dp_b1[1]);
        dpc_p2 <= dpc_p1;
    end

    mat2_vec_seq #(.W(16), .DP_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .dp_a0(dp_a0[0]), .dp_a1(dp_a1[0]), .dp_b0(dp_b0[0]), .dp_b1(dp_b1[0]),
        .dp_c(dpc_comb),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_y0(out_y0[0]), .out_y1(out_y1[0]), .busy(busy[0])
    );

    mat2_vec_seq #(.W(16), .DP_LAT(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .dp_a0(dp_a0[1]), .dp_a1(dp_a1[1]), .dp_b0(dp_b0[1]), .dp_b1(dp_b1[1]),
        .dp_c(dpc_p2),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_y0(out_y0[1]), .out_y1(out_y1[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; asserts reset mid-cycle and checks the asynchronous effect
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d rst out_valid", u), out_valid[u], 0);
            chk($sformatf("u%0d rst busy", u), busy[u], 0);
            chk($sformatf("u%0d rst dp_a0", u), dp_a0[u], 0);
            chk($sformatf("u%0d rst dp_b1", u), dp_b1[u], 0);
            chk($sformatf("u%0d rst y0", u), out_y0[u], 0);
            chk($sformatf("u%0d rst y1", u), out_y1[u], 0);
        end
        in_valid  = '0;
        out_ready = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++)
            chk($sformatf("u%0d post-rst in_ready", u), in_ready[u], 1);
    endtask

    // rst_at: -1 none, 0..5 reset before that word, 6 reset while the result waits
    task automatic run_job(input int u, input logic [5:0][15:0] w, input int max_gap,
                           input int stall, input bit check_dp, input int rst_at);
        logic [15:0] ey0, ey1;
        int n, row;
        ey0 = dot(w[0], w[1], w[4], w[5]);
        ey1 = dot(w[2], w[3], w[4], w[5]);
        for (int k = 0; k < 6; k++) begin
            if (k == rst_at) begin
                do_reset();
                return;
            end
            in_valid[u] = 1'b0;
            repeat ($urandom_range(0, max_gap)) begin
                in_data[u] = 16'($urandom);
                @(negedge clk);
            end
            in_valid[u] = 1'b1;
            in_data[u]  = w[k];
            n = 0;
            while (!in_ready[u] && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n == 20) chk($sformatf("u%0d in_ready timeout", u), in_ready[u], 1);
            @(negedge clk);
        end
        in_valid[u] = 1'b0;
        for (int i = 0; i < 2 * lat(u); i++) begin
            chk($sformatf("u%0d out_valid early c%0d", u, i), out_valid[u], 0);
            chk($sformatf("u%0d in_ready compute", u), in_ready[u], 0);
            chk($sformatf("u%0d busy compute", u), busy[u], 1);
            if (check_dp) begin
                row = i / lat(u);
                chk($sformatf("u%0d dp_a0 r%0d", u, row), dp_a0[u], row ? w[2] : w[0]);
                chk($sformatf("u%0d dp_a1 r%0d", u, row), dp_a1[u], row ? w[3] : w[1]);
                chk($sformatf("u%0d dp_b0 r%0d", u, row), dp_b0[u], w[4]);
                chk($sformatf("u%0d dp_b1 r%0d", u, row), dp_b1[u], w[5]);
            end
            @(negedge clk);
        end
        chk($sformatf("u%0d latency out_valid", u), out_valid[u], 1);
        if (rst_at == 6) begin
            do_reset();
            return;
        end
        out_ready[u] = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk($sformatf("u%0d stall out_valid", u), out_valid[u], 1);
            chk($sformatf("u%0d stall in_ready", u), in_ready[u], 0);
            chk($sformatf("u%0d stall y0", u), out_y0[u], ey0);
            chk($sformatf("u%0d stall y1", u), out_y1[u], ey1);
            @(negedge clk);
        end
        out_ready[u] = 1'b1;
        chk($sformatf("u%0d y0", u), out_y0[u], ey0);
        chk($sformatf("u%0d y1", u), out_y1[u], ey1);
        @(negedge clk);
        out_ready[u] = 1'b0;
        chk($sformatf("u%0d out_valid after hs", u), out_valid[u], 0);
        chk($sformatf("u%0d in_ready after hs", u), in_ready[u], 1);
        chk($sformatf("u%0d busy idle", u), busy[u], 0);
    endtask

    function automatic logic [5:0][15:0] rnd_job();
        logic [5:0][15:0] w;
        for (int k = 0; k < 6; k++) w[k] = 16'($urandom);
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0][15:0] j1, j2, j4;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        j1 = mk(16'hFE80, 16'hFE80, 16'hFE80, 16'hFE80, 16'h0080, 16'hFC80);
        j2 = mk(16'h0100, 16'h0000, 16'h0000, 16'h0200, 16'h0300, 16'h0400);
        j4 = mk(16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0100, 16'h0100);
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d reset out_valid", u), out_valid[u], 0);
            chk($sformatf("u%0d reset busy", u), busy[u], 0);
            chk($sformatf("u%0d reset dp_a1", u), dp_a1[u], 0);
            chk($sformatf("u%0d reset y0", u), out_y0[u], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("u0 in_ready after release", in_ready[0], 1);

        chk("model j1 y", {16'h0, dot(16'hFE80, 16'hFE80, 16'h0080, 16'hFC80)}, 32'h0480);
        run_job(0, j1, 0, 0, 1'b0, -1);
        run_job(0, j2, 0, 0, 1'b1, -1);
        run_job(0, rnd_job(), 3, 10, 1'b1, -1);
        run_job(0, j4, 0, 0, 1'b1, -1);

        run_job(0, rnd_job(), 0, 0, 1'b0, 3);
        run_job(0, rnd_job(), 1, 0, 1'b0, 6);
        run_job(0, j1, 0, 0, 1'b1, -1);

        run_job(1, j1, 0, 0, 1'b1, -1);
        run_job(1, j2, 2, 4, 1'b1, -1);
        run_job(1, j4, 0, 0, 1'b1, -1);

        for (int r = 0; r < 20; r++)
            run_job(int'($urandom_range(0, 1)), rnd_job(), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 5)), 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
